nbody_integrator: RTL and testbench
===================================

Name: nbody_integrator

Overview:
- Downstream stage of the N-body force engine.
- Once the force pass has written one 32-bit force word per body into the shared dual-port BRAM, this block walks every body record and applies one semi-implicit Euler step. It writes the updated position and velocity back in place.
- It uses the same start/done handshake as the force engine, so a top-level sequencer alternates force pass, then integrate pass, per timestep.

Parameters:
- N, 2, number of bodies (1..1024).
- BODY_BASE, 15'h000, BRAM address of body 0 record; body i at BODY_BASE+i.
- FORCE_BASE, 15'h190, BRAM address of force word for body 0; body i at FORCE_BASE+i.
- RD_LAT, 2, BRAM read latency in cycles from rd_addr to valid rd_data (>=1).
- DT_SHIFT, 4, timestep expressed as right shift (dt = 2^-DT_SHIFT).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a pass when idle.
- done  out  1  single-cycle pulse when the pass completes.
- busy  out  1  high from the cycle after accepted start until done.
- rd_addr  out  15  BRAM read address.
- rd_data  in  80  BRAM read data, valid RD_LAT cycles after rd_addr.
- wr_addr  out  15  BRAM write address.
- wr_data  out  80  BRAM write data.
- wren  out  1  BRAM write enable.

Behaviour:
- Record layout (80 b):
  - [79:64] pos_x, [63:48] pos_y, [47:32] vel_x, [31:16] vel_y, all signed 16 b.
  - [15:0] inv_mass, unsigned Q0.16.
- Force word is the low 32 b of the read: [31:16] fx, [15:0] fy, signed.
- Reset values:
  - done=0, busy=0, wren=0.
  - rd_addr=0, wr_addr=0, wr_data=0.
  - Body index=0, FSM=IDLE.
- Reset is asynchronous: asserting it mid-pass aborts immediately and drops wren. Memory is left partially updated; this is acceptable.
- FSM states: IDLE, RD_BODY, RD_FORCE, WAIT, MUL, WRITE, NEXT.
  - IDLE: on start go to RD_BODY with i=0. start is ignored while busy.
  - Per body, t = cycle in which rd_addr=BODY_BASE+i:
    - t+1: rd_addr=FORCE_BASE+i.
    - t+RD_LAT: capture body record.
    - t+RD_LAT+1: capture force word.
    - t+RD_LAT+2: MUL registers the accelerations.
    - t+RD_LAT+3: WRITE, wren=1 for exactly one cycle with wr_addr=BODY_BASE+i.
  - NEXT: if i==N-1, go to IDLE and pulse done in the same cycle busy falls. Otherwise i++ and go to RD_BODY.
  - Period is RD_LAT+4 cycles per body.
- Arithmetic:
  - a = (f * {1'b0,inv_mass}) >>> 16, computed as a signed 34-b product truncated to 17 b. This is lossless because |a| <= 32768.
  - v' = v + (a >>> DT_SHIFT), computed in 18 b.
  - p' = p + (v'_16 >>> DT_SHIFT), computed in 18 b, using the post-overflow-handling 16-b v'.
  - Shifts are arithmetic (floor).
- Overflow handling is set by the optional feature below.
- Write-back: inv_mass passes through unchanged. Force words are never written.
- N=1 is legal: exactly one write, then done.

Optional Feature:
- Macro NBODY_INTEG_SAT_EN.
- Defined: v' and p' saturate to [-32768, 32767].
- Undefined: v' and p' wrap to 16 b, two's complement. This saves area.

Decomposition:
- Package nbody_pkg:
  - body_t packed struct matching the 80-b layout.
  - force_t packed struct {fx, fy}.
  - Field-width localparams.
  - FSM state enum.
  - sat16 function.
- One sub-module, nbody_euler_dp:
  - Purely arithmetic datapath: body_t and force_t in, updated body_t out.
  - Registered multiply stage, so the FSM stays in nbody_integrator.

Test Plan:
- Basic step (N=1, DT_SHIFT=4):
  - Stimulus: body0 pos=(100,0), vel=(16,0), inv_mass=16'h8000; force (64,-32).
  - Required write: pos=(101,-1), vel=(18,-1), inv_mass=16'h8000.
- Saturation (N=1):
  - Stimulus: pos_x=32760, vel_x=32767, inv_mass=16'hFFFF, fx=32767.
  - With NBODY_INTEG_SAT_EN: vel_x=32767, pos_x=32767.
  - Without it: vel_x=-30722, pos_x=30839.
- Timing (N=2, RD_LAT=2):
  - Check wren high in exactly 2 cycles, 6 cycles apart.
  - Check wr_addr 0 then 1.
  - Check done one cycle after the second write.
  - Check busy high for 12 cycles.
- Start while busy:
  - Pulse start again mid-pass.
  - Required: no restart, exactly N writes, a single done.
- Reset mid-pass:
  - Deassert reset_n during WAIT of body 1.
  - Required: wren=0 and busy=0 immediately, body 1 unchanged in memory, next start completes normally.
- Zero force (N=3):
  - Stimulus: all forces 0, vel=(32,-32).
  - Required: pos moves by (2,-2) per body, vel unchanged.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared types for the N-body integrate pass: record layouts, field widths,
// FSM state encoding and the 16-bit saturation helper.
package nbody_pkg;

    localparam int ADDR_W  = 15;
    localparam int REC_W   = 80;
    localparam int FIELD_W = 16;
    localparam int FORCE_W = 32;
    localparam int ACC_W   = 17;
    localparam int SUM_W   = 18;
    localparam int PROD_W  = 34;

    localparam logic signed [SUM_W-1:0] S16_MAX = 18'sd32767;
    localparam logic signed [SUM_W-1:0] S16_MIN = -18'sd32768;

    typedef struct packed {
        logic signed [FIELD_W-1:0] pos_x;
        logic signed [FIELD_W-1:0] pos_y;
        logic signed [FIELD_W-1:0] vel_x;
        logic signed [FIELD_W-1:0] vel_y;
        logic        [FIELD_W-1:0] inv_mass;
    } body_t;

    typedef struct packed {
        logic signed [FIELD_W-1:0] fx;
        logic signed [FIELD_W-1:0] fy;
    } force_t;

    typedef enum logic [2:0] {
        IDLE, RD_BODY, RD_FORCE, WAIT, MUL, WRITE, NEXT
    } state_t;

    function automatic logic signed [FIELD_W-1:0] sat16(input logic signed [SUM_W-1:0] x);
        if (x > S16_MAX) begin
            return 16'sh7FFF;
        end else if (x < S16_MIN) begin
            return 16'sh8000;
        end else begin
            return FIELD_W'(x);
        end
    endfunction

endpackage

// File: rtl/nbody_integrator_if.sv
// Bus bundle between the integrator, its sequencer and the shared body/force BRAM.
interface nbody_integrator_if;
    import nbody_pkg::*;

    // start is a one-cycle request honoured only while idle; busy rises the next
    // cycle and falls in the same cycle done pulses for one cycle.
    logic              start;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [REC_W-1:0]  rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [REC_W-1:0]  wr_data;
    logic              wren;

    modport master (
        input  start, rd_data,
        output done, busy, rd_addr, wr_addr, wr_data, wren
    );

    modport slave (
        output start, rd_data,
        input  done, busy, rd_addr, wr_addr, wr_data, wren
    );

endinterface

// File: rtl/nbody_euler_dp.sv
// Semi-implicit Euler datapath: registered acceleration stage, then velocity and
// position update. NBODY_INTEG_SAT_EN selects saturation instead of wrap.
module nbody_euler_dp
    import nbody_pkg::*;
#(
    parameter int DT_SHIFT = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   acc_en,
    input  body_t  body_i,
    input  force_t force_i,
    output body_t  body_o
);

    logic signed [PROD_W-1:0] prod_x, prod_y;
    logic signed [ACC_W-1:0]  acc_x_d, acc_x_q, acc_y_d, acc_y_q;
    logic [2*FIELD_W-1:0]     upd_x, upd_y;

    // Position uses the already-limited 16-bit velocity, not the raw 18-bit sum.
    function automatic logic [2*FIELD_W-1:0] step_axis(
        input logic signed [FIELD_W-1:0] pos,
        input logic signed [FIELD_W-1:0] vel,
        input logic signed [ACC_W-1:0]   acc
    );
        logic signed [ACC_W-1:0]   dv;
        logic signed [SUM_W-1:0]   v_sum, p_sum;
        logic signed [FIELD_W-1:0] v_new, dpos, p_new;
        dv    = acc >>> DT_SHIFT;
        v_sum = SUM_W'(vel) + SUM_W'(dv);
`ifdef NBODY_INTEG_SAT_EN
        v_new = sat16(v_sum);
`else
        v_new = FIELD_W'(v_sum);
`endif
        dpos  = v_new >>> DT_SHIFT;
        p_sum = SUM_W'(pos) + SUM_W'(dpos);
`ifdef NBODY_INTEG_SAT_EN
        p_new = sat16(p_sum);
`else
        p_new = FIELD_W'(p_sum);
`endif
        return {p_new, v_new};
    endfunction

    always_comb begin
        prod_x  = $signed({{(PROD_W-FIELD_W){force_i.fx[FIELD_W-1]}}, force_i.fx})
                * $signed({{(PROD_W-FIELD_W){1'b0}}, body_i.inv_mass});
        prod_y  = $signed({{(PROD_W-FIELD_W){force_i.fy[FIELD_W-1]}}, force_i.fy})
                * $signed({{(PROD_W-FIELD_W){1'b0}}, body_i.inv_mass});
        acc_x_d = acc_en ? ACC_W'(prod_x >>> 16) : acc_x_q;
        acc_y_d = acc_en ? ACC_W'(prod_y >>> 16) : acc_y_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_x_q <= '0;
            acc_y_q <= '0;
        end else begin
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
        end
    end

    always_comb begin
        upd_x           = step_axis(body_i.pos_x, body_i.vel_x, acc_x_q);
        upd_y           = step_axis(body_i.pos_y, body_i.vel_y, acc_y_q);
        body_o.pos_x    = upd_x[2*FIELD_W-1:FIELD_W];
        body_o.vel_x    = upd_x[FIELD_W-1:0];
        body_o.pos_y    = upd_y[2*FIELD_W-1:FIELD_W];
        body_o.vel_y    = upd_y[FIELD_W-1:0];
        body_o.inv_mass = body_i.inv_mass;
    end

endmodule

// File: rtl/nbody_integrator.sv
// Integrate pass: walks every body, reads record + force, writes the Euler-updated
// record back in place. Overflow mode follows NBODY_INTEG_SAT_EN (see datapath).
module nbody_integrator
    import nbody_pkg::*;
#(
    parameter int                N          = 2,
    parameter logic [ADDR_W-1:0] BODY_BASE  = 15'h000,
    parameter logic [ADDR_W-1:0] FORCE_BASE = 15'h190,
    parameter int                RD_LAT     = 2,
    parameter int                DT_SHIFT   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    nbody_integrator_if.master  bus,
    output state_t              dbg_state
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CYC_W = $clog2(RD_LAT + 4);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [CYC_W-1:0] BODY_CYC  = CYC_W'(RD_LAT);
    localparam logic [CYC_W-1:0] FORCE_CYC = CYC_W'(RD_LAT + 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic              wren_q, wren_d, done_q, done_d, busy_q, busy_d;
    body_t             body_q, body_d, body_new;
    force_t            force_q, force_d;
    logic              acc_en;

    nbody_euler_dp #(.DT_SHIFT(DT_SHIFT)) u_dp (
        .clk     (clk),
        .reset_n (reset_n),
        .acc_en  (acc_en),
        .body_i  (body_q),
        .force_i (force_q),
        .body_o  (body_new)
    );

    // cyc counts cycles since this body's RD_BODY; captures key off it so they
    // line up with RD_LAT regardless of which state is current.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cyc_d     = cyc_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wren_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        body_d    = body_q;
        force_d   = force_q;
        acc_en    = 1'b0;
        if (busy_q) cyc_d = cyc_q + CYC_W'(1);
        if (busy_q && cyc_q == BODY_CYC)  body_d  = body_t'(bus.rd_data);
        if (busy_q && cyc_q == FORCE_CYC) force_d = force_t'(bus.rd_data[FORCE_W-1:0]);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RD_BODY;
                    idx_d     = '0;
                    cyc_d     = '0;
                    rd_addr_d = BODY_BASE;
                    busy_d    = 1'b1;
                end
            end
            RD_BODY: begin
                state_d   = RD_FORCE;
                rd_addr_d = FORCE_BASE + ADDR_W'(idx_q);
            end
            RD_FORCE: state_d = WAIT;
            WAIT: begin
                if (cyc_q == FORCE_CYC) state_d = MUL;
            end
            MUL: begin
                acc_en    = 1'b1;
                wren_d    = 1'b1;
                wr_addr_d = BODY_BASE + ADDR_W'(idx_q);
                state_d   = WRITE;
            end
            WRITE: begin
                // Non-final bodies chain straight into the next read so the
                // per-body period stays at RD_LAT+4.
                if (idx_q == LAST_IDX) begin
                    state_d = NEXT;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    cyc_d     = '0;
                    rd_addr_d = BODY_BASE + ADDR_W'(idx_q + IDX_W'(1));
                    state_d   = RD_BODY;
                end
            end
            NEXT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cyc_q     <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wren_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            body_q    <= '0;
            force_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wren_q    <= wren_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            body_q    <= body_d;
            force_q   <= force_d;
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = body_new;
    assign bus.wren    = wren_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_nbody_integrator.sv
// Directed bench for nbody_integrator: N=1 vector table plus N=2 timing, restart
// and mid-pass reset sequences against a behavioural BRAM with RD_LAT=2.
module tb_nbody_integrator;
    import nbody_pkg::*;

    localparam logic [8:0] F_IDX = 9'h190;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nbody_integrator_if bus_a ();
    nbody_integrator_if bus_b ();
    state_t dbg_a, dbg_b;

    nbody_integrator #(.N(2), .BODY_BASE(15'h000), .FORCE_BASE(15'h190), .RD_LAT(2), .DT_SHIFT(4))
        u_dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a));
    nbody_integrator #(.N(1), .BODY_BASE(15'h000), .FORCE_BASE(15'h190), .RD_LAT(2), .DT_SHIFT(4))
        u_dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b));

    // Behavioural dual-port BRAM per DUT, two-cycle read latency
    logic [79:0] mem_a [0:511];
    logic [79:0] mem_b [0:511];
    logic [79:0] stg_a, stg_b;
    logic        ld_we;
    logic [8:0]  ld_addr;
    logic [79:0] ld_data;

    always @(posedge clk) begin
        if (ld_we) begin
            mem_a[ld_addr] <= ld_data;
            mem_b[ld_addr] <= ld_data;
        end
        if (bus_a.wren) mem_a[bus_a.wr_addr[8:0]] <= bus_a.wr_data;
        if (bus_b.wren) mem_b[bus_b.wr_addr[8:0]] <= bus_b.wr_data;
        stg_a         <= mem_a[bus_a.rd_addr[8:0]];
        stg_b         <= mem_b[bus_b.rd_addr[8:0]];
        bus_a.rd_data <= stg_a;
        bus_b.rd_data <= stg_b;
    end

    // Monitor: append-only logs sampled on the falling edge
    int          cyc = 0;
    int          done_cnt_a = 0, done_cnt_b = 0, busy_cnt_a = 0, done_cyc_a = 0;
    logic [14:0] wa_addr_q[$];
    logic [79:0] wa_data_q[$];
    int          wa_cyc_q[$];
    logic [14:0] wb_addr_q[$];
    logic [79:0] wb_data_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.wren) begin
            wa_addr_q.push_back(bus_a.wr_addr);
            wa_data_q.push_back(bus_a.wr_data);
            wa_cyc_q.push_back(cyc);
        end
        if (bus_b.wren) begin
            wb_addr_q.push_back(bus_b.wr_addr);
            wb_data_q.push_back(bus_b.wr_data);
        end
        if (bus_a.done) begin
            done_cnt_a <= done_cnt_a + 1;
            done_cyc_a <= cyc;
        end
        if (bus_b.done) done_cnt_b <= done_cnt_b + 1;
        if (bus_a.busy) busy_cnt_a <= busy_cnt_a + 1;
    end

    // Scoreboard
    int          n_checks = 0;
    int          n_pass = 0;
    logic [79:0] exp_q[$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic body_t mk_body(input int px, input int py, input int vx, input int vy, input int im);
        body_t b;
        b.pos_x = 16'(px);
        b.pos_y = 16'(py);
        b.vel_x = 16'(vx);
        b.vel_y = 16'(vy);
        b.inv_mass = 16'(im);
        return b;
    endfunction

    function automatic force_t mk_force(input int fx, input int fy);
        force_t f;
        f.fx = 16'(fx);
        f.fy = 16'(fy);
        return f;
    endfunction

    // Driver tasks, all entered and left on a falling edge
    task automatic load(input logic [8:0] addr, input logic [79:0] data);
        ld_we = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic load_body(input int idx, input body_t b, input force_t f);
        load(9'(idx), b);
        load(F_IDX + 9'(idx), {48'h0, f});
    endtask

    task automatic pulse_start(input bit sel_b);
        if (sel_b) bus_b.start = 1'b1;
        else bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input int base);
        int k = 0;
        while (((sel_b ? done_cnt_b : done_cnt_a) == base) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(sel_b ? "done_b_seen" : "done_a_seen",
              80'((sel_b ? done_cnt_b : done_cnt_a) != base), 80'(1));
    endtask

    typedef struct {
        string  name;
        body_t  body;
        force_t frc;
        body_t  exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wb0, db0, wa0, da0, ba0, k;
        body_t b0, b1;

        ld_we = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        vecs[0] = '{"basic", mk_body(100, 0, 16, 0, 'h8000), mk_force(64, -32),
                    mk_body(101, -1, 18, -1, 'h8000)};
`ifdef NBODY_INTEG_SAT_EN
        vecs[1] = '{"sat_pos", mk_body(32760, 0, 32767, 0, 'hFFFF), mk_force(32767, 0),
                    mk_body(32767, 0, 32767, 0, 'hFFFF)};
        vecs[2] = '{"sat_neg", mk_body(-32760, 0, -32768, 0, 'hFFFF), mk_force(-32768, 0),
                    mk_body(-32768, 0, -32768, 0, 'hFFFF)};
`else
        vecs[1] = '{"wrap_pos", mk_body(32760, 0, 32767, 0, 'hFFFF), mk_force(32767, 0),
                    mk_body(30839, 0, -30722, 0, 'hFFFF)};
        vecs[2] = '{"wrap_neg", mk_body(-32760, 0, -32768, 0, 'hFFFF), mk_force(-32768, 0),
                    mk_body(-30840, 0, 30720, 0, 'hFFFF)};
`endif
        vecs[3] = '{"zero_force", mk_body(-5, 7, 32, -32, 'h1234), mk_force(0, 0),
                    mk_body(-3, 5, 32, -32, 'h1234)};
        vecs[4] = '{"floor_shift", mk_body(0, 0, 0, 0, 'hFFFF), mk_force(-1, 1),
                    mk_body(-1, 0, -1, 0, 'hFFFF)};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wren", 80'(bus_a.wren), 80'(0));
        check("rst_busy", 80'(bus_a.busy), 80'(0));
        check("rst_done", 80'(bus_a.done), 80'(0));
        check("rst_rd_addr", 80'(bus_a.rd_addr), 80'(0));
        check("rst_wr_addr", 80'(bus_a.wr_addr), 80'(0));
        check("rst_wr_data", bus_a.wr_data, 80'(0));
        check("rst_state", 80'(dbg_a), 80'(IDLE));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table on the N=1 instance
        for (int i = 0; i < 5; i++) begin
            load_body(0, vecs[i].body, vecs[i].frc);
            wb0 = wb_addr_q.size();
            db0 = done_cnt_b;
            pulse_start(1'b1);
            wait_done(1'b1, db0);
            repeat (3) @(negedge clk);
            check({vecs[i].name, "_wr_count"}, 80'(wb_addr_q.size() - wb0), 80'(1));
            if (wb_addr_q.size() > wb0) begin
                check({vecs[i].name, "_wr_addr"}, 80'(wb_addr_q[wb0]), 80'(0));
                check({vecs[i].name, "_wr_data"}, wb_data_q[wb0], vecs[i].exp);
            end
            check({vecs[i].name, "_mem"}, mem_b[0], vecs[i].exp);
        end

        // Timing with N=2
        load_body(0, mk_body(100, 0, 16, 0, 'h8000), mk_force(64, -32));
        load_body(1, mk_body(-5, 7, 32, -32, 'h1234), mk_force(0, 0));
        exp_q.push_back(mk_body(101, -1, 18, -1, 'h8000));
        exp_q.push_back(mk_body(-3, 5, 32, -32, 'h1234));
        wa0 = wa_addr_q.size();
        da0 = done_cnt_a;
        ba0 = busy_cnt_a;
        pulse_start(1'b0);
        wait_done(1'b0, da0);
        repeat (4) @(negedge clk);
        check("tim_wr_count", 80'(wa_addr_q.size() - wa0), 80'(2));
        check("tim_busy_cycles", 80'(busy_cnt_a - ba0), 80'(12));
        check("tim_done_count", 80'(done_cnt_a - da0), 80'(1));
        if (wa_addr_q.size() >= wa0 + 2) begin
            check("tim_wr_spacing", 80'(wa_cyc_q[wa0+1] - wa_cyc_q[wa0]), 80'(6));
            check("tim_wr_addr0", 80'(wa_addr_q[wa0]), 80'(0));
            check("tim_wr_addr1", 80'(wa_addr_q[wa0+1]), 80'(1));
            check("tim_done_after_wr", 80'(done_cyc_a - wa_cyc_q[wa0+1]), 80'(1));
            for (int j = 0; j < 2; j++) begin
                check("tim_wr_data", wa_data_q[wa0+j], exp_q.pop_front());
            end
        end

        // Start while busy, zero force on both bodies
        load_body(0, mk_body(10, 20, 32, -32, 'h4000), mk_force(0, 0));
        load_body(1, mk_body(-100, 50, 32, -32, 'hFFFF), mk_force(0, 0));
        wa0 = wa_addr_q.size();
        da0 = done_cnt_a;
        pulse_start(1'b0);
        repeat (3) @(negedge clk);
        pulse_start(1'b0);
        repeat (5) @(negedge clk);
        pulse_start(1'b0);
        wait_done(1'b0, da0);
        repeat (20) @(negedge clk);
        check("rst_busy_wr_count", 80'(wa_addr_q.size() - wa0), 80'(2));
        check("rst_busy_done_count", 80'(done_cnt_a - da0), 80'(1));
        check("zero_body0", mem_a[0], mk_body(12, 18, 32, -32, 'h4000));
        check("zero_body1", mem_a[1], mk_body(-98, 48, 32, -32, 'hFFFF));

        // Reset during WAIT of body 1
        b0 = mk_body(200, -200, 0, 0, 'h8000);
        b1 = mk_body(1000, -1000, -16, 16, 'hFFFF);
        load_body(0, b0, mk_force(160, -160));
        load_body(1, b1, mk_force(16, -16));
        wa0 = wa_addr_q.size();
        pulse_start(1'b0);
        k = 0;
        while (wa_addr_q.size() == wa0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (dbg_a != WAIT && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_reached_wait", 80'(dbg_a), 80'(WAIT));
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_wren", 80'(bus_a.wren), 80'(0));
        check("mid_rst_busy", 80'(bus_a.busy), 80'(0));
        check("mid_rst_state", 80'(dbg_a), 80'(IDLE));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_body1_untouched", mem_a[1], b1);
        check("mid_body0_once", mem_a[0], mk_body(200, -201, 5, -5, 'h8000));
        da0 = done_cnt_a;
        pulse_start(1'b0);
        wait_done(1'b0, da0);
        repeat (3) @(negedge clk);
        check("rerun_body0_twice", mem_a[0], mk_body(200, -202, 10, -10, 'h8000));
        check("rerun_body1_once", mem_a[1], mk_body(999, -1000, -16, 15, 'hFFFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
